// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage memory definitions: widths, responder FSM states, request payload.
package mips_mem_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BE_W        = 4;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned ADDR_FULL_W = 32;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned WAIT_MAX    = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic                   write;
    logic [ADDR_FULL_W-1:0] addr;
    logic [WORD_W-1:0]      wdata;
    logic [BE_W-1:0]        be;
  } mem_req_t;

  // True when any word-index bit above the RAM's address range is set.
  function automatic logic addr_out_of_range(input logic [ADDR_FULL_W-1:0] addr,
                                             input int unsigned            addr_w);
    return (addr >> addr_w) != '0;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory bus.
//   master: MEM stage (drives req_*, sees resp_* and stall)
//   slave : data_mem_responder (drives resp_* and stall)
interface data_mem_responder_if;
  import mips_mem_pkg::*;

  logic                   req_valid;
  logic                   req_write;
  logic [ADDR_FULL_W-1:0] req_addr;
  logic [WORD_W-1:0]      req_wdata;
  logic [BE_W-1:0]        req_be;
  logic                   resp_valid;
  logic [WORD_W-1:0]      resp_rdata;
  logic                   resp_err;
  logic                   stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/data_mem_array.sv
// Single-port synchronous RAM, 2**ADDR_W x WORD_W, per-byte write enable, registered read.
//   clk   : clock
//   re    : read strobe; rdata updates only on a read, otherwise holds
//   we    : per-byte write enables
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
module data_mem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              re,
  input  logic [BE_W-1:0]   we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-masked write and read-register update share the single port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(BE_W); i++) begin
      if (we[i]) mem[addr][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage data-memory interface. Accepts one load/store,
// serves it from a local RAM after WAIT_STATES extra cycles, pulses a one-cycle
// response, and drives the combinational pipeline stall.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : request/response bus (slave side)
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES - 1);

  generate
    if (WAIT_STATES > WAIT_MAX) begin : g_bad_wait
      $error("data_mem_responder: WAIT_STATES must be in 0..15");
    end
    if (ADDR_W < 1 || ADDR_W >= ADDR_FULL_W) begin : g_bad_addr
      $error("data_mem_responder: ADDR_W must be in 1..31");
    end
  endgenerate

  mem_state_e        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  mem_req_t          req_q;
  mem_req_t          cur;
  logic              commit;
  logic              cur_err;
  logic              ram_re;
  logic [BE_W-1:0]   ram_we;
  logic [WORD_W-1:0] ram_rdata;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic              rdata_zero_q;

  // State register, capture registers and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      req_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_zero_q <= 1'b1;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      resp_valid_q <= commit;
      if (state == IDLE && bus.req_valid) req_q <= cur;
      if (commit) begin
        resp_err_q <= cur_err;
        if (!cur.write) rdata_zero_q <= cur_err;
      end
    end
  end

  // Next state, wait countdown and the commit strobes into the RAM.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cur     = req_q;
    case (state)
      IDLE: begin
        // With zero wait states the commit happens on the accepting edge,
        // so the live request fields feed the RAM directly.
        cur = '{write: bus.req_write, addr: bus.req_addr,
                wdata: bus.req_wdata, be: bus.req_be};
        if (bus.req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_d = RESP;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    commit  = (state != RESP) && (state_d == RESP) && !reset;
    cur_err = addr_out_of_range(cur.addr, ADDR_W);
    ram_re  = commit && !cur_err && !cur.write;
    ram_we  = (commit && !cur_err && cur.write) ? cur.be : '0;
  end

  data_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (cur.addr[ADDR_W-1:0]),
    .wdata (cur.wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register holds load data between responses; the zero flag
  // covers reset and out-of-range loads.
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = rdata_zero_q ? '0 : ram_rdata;
  assign bus.stall      = bus.req_valid & ~resp_valid_q;

endmodule
